// File: rtl/half_adder_if.sv
// Valid/ready operand and result channels of the half-adder bank.
// master drives operands and accepts results; slave is the adder side.
interface half_adder_if #(
  parameter int WIDTH = 1,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] cout;
  logic [CW-1:0]    carry_count;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, carry_count
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, cout, carry_count
  );
endinterface

// File: rtl/half_adder.sv
// Bank of WIDTH independent half adders behind a registered output stage
// with a one-entry skid buffer, so in_ready never depends on out_ready.
module half_adder #(
  parameter int WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  half_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] cnt;
    cnt = {CW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CW'(v[i]);
    end
    return cnt;
  endfunction

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] cout_s;
  logic [CW-1:0]    cnt_s;
  logic             accept_s;
  logic             drain_s;

  logic [WIDTH-1:0] main_sum_q,   main_sum_d;
  logic [WIDTH-1:0] main_cout_q,  main_cout_d;
  logic [CW-1:0]    main_cnt_q,   main_cnt_d;
  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] skid_sum_q,   skid_sum_d;
  logic [WIDTH-1:0] skid_cout_q,  skid_cout_d;
  logic [CW-1:0]    skid_cnt_q,   skid_cnt_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q,   in_ready_d;

  assign sum_s    = bus.a ^ bus.b;
  assign cout_s   = bus.a & bus.b;
  assign cnt_s    = popcount(cout_s);
  assign accept_s = bus.in_valid & in_ready_q;
  assign drain_s  = main_valid_q & bus.out_ready;

  // Next-state of the main/skid pair; accept is impossible while skid is full.
  always_comb begin
    main_sum_d   = main_sum_q;
    main_cout_d  = main_cout_q;
    main_cnt_d   = main_cnt_q;
    main_valid_d = main_valid_q;
    skid_sum_d   = skid_sum_q;
    skid_cout_d  = skid_cout_q;
    skid_cnt_d   = skid_cnt_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      if (drain_s) begin
        main_sum_d   = skid_sum_q;
        main_cout_d  = skid_cout_q;
        main_cnt_d   = skid_cnt_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = main_valid_q;
      end
    end else if (accept_s) begin
      if (!main_valid_q || drain_s) begin
        main_sum_d   = sum_s;
        main_cout_d  = cout_s;
        main_cnt_d   = cnt_s;
        main_valid_d = 1'b1;
      end else begin
        skid_sum_d   = sum_s;
        skid_cout_d  = cout_s;
        skid_cnt_d   = cnt_s;
        skid_valid_d = 1'b1;
      end
    end else if (drain_s) begin
      main_valid_d = 1'b0;
    end else begin
      main_valid_d = main_valid_q;
    end
    in_ready_d = ~skid_valid_d;
  end

  // Output and skid registers; data is kept when a register empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_sum_q   <= {WIDTH{1'b0}};
      main_cout_q  <= {WIDTH{1'b0}};
      main_cnt_q   <= {CW{1'b0}};
      main_valid_q <= 1'b0;
      skid_sum_q   <= {WIDTH{1'b0}};
      skid_cout_q  <= {WIDTH{1'b0}};
      skid_cnt_q   <= {CW{1'b0}};
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_sum_q   <= main_sum_d;
      main_cout_q  <= main_cout_d;
      main_cnt_q   <= main_cnt_d;
      main_valid_q <= main_valid_d;
      skid_sum_q   <= skid_sum_d;
      skid_cout_q  <= skid_cout_d;
      skid_cnt_q   <= skid_cnt_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.sum         = main_sum_q;
  assign bus.cout        = main_cout_q;
  assign bus.carry_count = main_cnt_q;
  assign bus.out_valid   = main_valid_q;
  assign bus.in_ready    = in_ready_q;
endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: WIDTH=1 truth table plus a WIDTH=8 instance
// for arithmetic, backpressure, random streaming and mid-stream reset.
module tb_half_adder;
  logic clk;
  logic rst_n;

  half_adder_if #(.WIDTH(1)) if1 ();
  half_adder_if #(.WIDTH(8)) if8 ();

  half_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  half_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  int n_total = 0;
  int n_pass  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check8(input string tag, input logic [7:0] s, input logic [7:0] c,
                        input logic [3:0] n);
    check({tag, "_valid"}, 32'(if8.out_valid), 32'd1);
    check({tag, "_sum"},   32'(if8.sum),       32'(s));
    check({tag, "_cout"},  32'(if8.cout),      32'(c));
    check({tag, "_cnt"},   32'(if8.carry_count), 32'(n));
  endtask

  logic [3:0]  tt_sum;
  logic [3:0]  tt_cout;
  logic [7:0]  ra, rb;
  logic [19:0] exp_q[$];
  logic [19:0] obs_w, exp_w;
  logic [31:0] held;
  logic        stall;
  int          sent, recv;

  initial begin
    rst_n = 1'b1;
    if1.in_valid = 1'b0; if1.a = 1'b0; if1.b = 1'b0; if1.out_ready = 1'b1;
    if8.in_valid = 1'b0; if8.a = 8'h00; if8.b = 8'h00; if8.out_ready = 1'b1;

    // asynchronous reset, applied before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(if8.out_valid), 32'd0);
    check("rst_sum",   32'(if8.sum), 32'd0);
    check("rst_cout",  32'(if8.cout), 32'd0);
    check("rst_cnt",   32'(if8.carry_count), 32'd0);
    check("rst_ready", 32'(if8.in_ready), 32'd1);
    check("rst1_valid", 32'(if1.out_valid), 32'd0);
    check("rst1_ready", 32'(if1.in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 truth table, one beat per cycle
    tt_sum  = 4'b0110;
    tt_cout = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        check("tt_valid", 32'(if1.out_valid), 32'd1);
        check("tt_sum",   32'(if1.sum),  32'(tt_sum[k-1]));
        check("tt_cout",  32'(if1.cout), 32'(tt_cout[k-1]));
        check("tt_cnt",   32'(if1.carry_count), 32'(tt_cout[k-1]));
      end
      if (k < 4) begin
        if1.in_valid = 1'b1;
        if1.a = k[1];
        if1.b = k[0];
      end else begin
        if1.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("tt_drained", 32'(if1.out_valid), 32'd0);

    // WIDTH=8 vectors
    if8.in_valid = 1'b1; if8.a = 8'hF0; if8.b = 8'hCC;
    @(negedge clk);
    check8("w8_a", 8'h3C, 8'hC0, 4'd2);
    if8.a = 8'hFF; if8.b = 8'hFF;
    @(negedge clk);
    check8("w8_b", 8'h00, 8'hFF, 4'd8);
    if8.in_valid = 1'b0;
    @(negedge clk);
    check("w8_drained", 32'(if8.out_valid), 32'd0);

    // backpressure: two beats absorbed, third held upstream
    if8.out_ready = 1'b0;
    if8.in_valid = 1'b1; if8.a = 8'h0F; if8.b = 8'h03;
    @(negedge clk);
    check8("bp_b0", 8'h0C, 8'h03, 4'd2);
    check("bp_ready1", 32'(if8.in_ready), 32'd1);
    if8.a = 8'hAA; if8.b = 8'h55;
    @(negedge clk);
    check("bp_ready2", 32'(if8.in_ready), 32'd0);
    check8("bp_hold0", 8'h0C, 8'h03, 4'd2);
    if8.a = 8'h81; if8.b = 8'h83;
    @(negedge clk);
    check("bp_ready3", 32'(if8.in_ready), 32'd0);
    check8("bp_hold1", 8'h0C, 8'h03, 4'd2);
    if8.out_ready = 1'b1;
    @(negedge clk);
    check8("bp_b1", 8'hFF, 8'h00, 4'd0);
    check("bp_ready4", 32'(if8.in_ready), 32'd1);
    @(negedge clk);
    check8("bp_b2", 8'h02, 8'h81, 4'd2);
    if8.in_valid = 1'b0;
    @(negedge clk);
    check("bp_drained", 32'(if8.out_valid), 32'd0);

    // random streaming against an in-order scoreboard
    sent = 0; recv = 0; stall = 1'b0; held = 32'd0;
    for (int cyc = 0; cyc < 8000 && recv < 1000; cyc++) begin
      if (stall) begin
        check("stable", {11'd0, if8.carry_count, if8.cout, if8.sum, if8.out_valid}, held);
      end
      if8.out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 1000) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        if8.in_valid = ($urandom_range(0, 3) != 0);
        if8.a = ra;
        if8.b = rb;
      end else begin
        if8.in_valid = 1'b0;
      end
      if (if8.in_valid && if8.in_ready) begin
        exp_q.push_back({4'($countones(ra & rb)), ra & rb, ra ^ rb});
        sent++;
      end
      if (if8.out_valid && if8.out_ready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          obs_w = {if8.carry_count, if8.cout, if8.sum};
          exp_w = exp_q.pop_front();
          check("stream", 32'(obs_w), 32'(exp_w));
          recv++;
        end
      end
      stall = if8.out_valid && !if8.out_ready;
      held  = {11'd0, if8.carry_count, if8.cout, if8.sum, if8.out_valid};
      @(negedge clk);
    end
    check("stream_recv", 32'(recv), 32'd1000);
    check("stream_left", 32'(exp_q.size()), 32'd0);
    if8.out_ready = 1'b1;
    if8.in_valid = 1'b0;
    @(negedge clk);

    // mid-stream reset with both buffers full
    if8.out_ready = 1'b0;
    if8.in_valid = 1'b1; if8.a = 8'h33; if8.b = 8'h0F;
    @(negedge clk);
    if8.a = 8'h12; if8.b = 8'h34;
    @(negedge clk);
    if8.in_valid = 1'b0;
    check("mr_full", 32'(if8.in_ready), 32'd0);
    check("mr_valid_pre", 32'(if8.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(if8.out_valid), 32'd0);
    check("mr_ready", 32'(if8.in_ready), 32'd1);
    check("mr_sum",   32'(if8.sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if8.out_ready = 1'b1;
    if8.in_valid = 1'b1; if8.a = 8'h5A; if8.b = 8'h3C;
    @(negedge clk);
    check8("mr_first", 8'h66, 8'h18, 4'd2);
    if8.in_valid = 1'b0;
    @(negedge clk);
    check("mr_no_stale", 32'(if8.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/half_adder.md
# half_adder

Registered, flow-controlled bank of independent half adders. Each of WIDTH lanes computes sum = a XOR b and cout = a AND b per bit. Results leave through a one-deep output register backed by a skid buffer. It is a leaf arithmetic block sitting between a valid/ready producer and consumer. With WIDTH = 1 it is the classic single-bit half adder (a = 1, b = 1 gives sum = 0, cout = 1).

## Interface
- WIDTH, default 1: number of independent half-adder lanes (≥ 1).
- CW, default $clog2(WIDTH+1): width of carry_count (derived, not overridden).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  a/b operand beat is valid.
- in_ready  output  1  block can accept an operand beat.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- out_valid  output  1  result beat is valid.
- out_ready  input  1  consumer accepts the result beat.
- sum  output  WIDTH  per-lane a XOR b.
- cout  output  WIDTH  per-lane a AND b.
- carry_count  output  CW  number of set bits in cout (popcount), unsigned.

## Operation
- Combinational core per lane i: s[i] = a[i] ^ b[i]; c[i] = a[i] & b[i]. No carry propagates between lanes.
- carry_count = popcount(c), computed on the accepted beat and registered together with sum/cout. The maximum value WIDTH always fits in CW bits.
- Input accept: a beat transfers when in_valid && in_ready at a rising clk edge.
- Output transfer: a beat transfers when out_valid && out_ready at a rising clk edge.
- Storage: a main output register (drives sum/cout/carry_count/out_valid) plus one skid register.
  - Accepted beat, main register empty or draining this cycle, skid empty: the beat goes to the main register.
  - Accepted beat while main is full and not draining: the beat goes to skid.
  - Main drains with skid full: skid moves into main and skid clears.
- in_ready = NOT skid_full. It is a registered signal and never depends combinationally on out_ready.
- Beats leave in acceptance order. No beat is dropped or duplicated.
- Outputs are held stable while out_valid && !out_ready.
- Data outputs when out_valid = 0 hold their last values. Consumers must ignore them.

## Timing
- Reset (rst_n low, asynchronous): out_valid = 0, sum = 0, cout = 0, carry_count = 0, skid empty, in_ready = 1. All of these take effect immediately, without waiting for clk.
- Reset deassertion is synchronised by the integrator. The first accept is possible on the first rising edge after rst_n goes high.
- Latency: a beat accepted at edge N is on sum/cout/carry_count with out_valid = 1 after edge N when the output path is free.
- Throughput: one beat per cycle sustained while out_ready = 1.
- Backpressure: with out_ready = 0, two beats are absorbed (main + skid). in_ready falls after the edge that fills skid.
  - in_ready rises again after the edge on which skid empties.
- Simultaneous accept and drain with skid empty: the new beat replaces the drained one in main, and out_valid stays 1.
- Reset asserted mid-stream: all buffered beats are discarded and outputs return to reset values at once.

## Test plan
- Reset: drive rst_n = 0 between clock edges. Required: out_valid = 0, sum = 0, cout = 0, carry_count = 0, in_ready = 1, all asynchronously.
- WIDTH = 1 truth table: send (a,b) = 00, 01, 10, 11 with out_ready = 1. Required (sum,cout) = 00, 10, 10, 01, each appearing one cycle after its accept; carry_count = 0, 0, 0, 1.
- WIDTH = 8: a = 8'hF0, b = 8'hCC. Required: sum = 8'h3C, cout = 8'hC0, carry_count = 2.
  - Then a = b = 8'hFF. Required: sum = 8'h00, cout = 8'hFF, carry_count = 8.
- Backpressure: hold out_ready = 0 and offer three beats. Required: first two accepted, in_ready = 0 after the second, third held upstream.
  - Then release out_ready. Required: all three emerge in order, none lost or repeated.
- Streaming: random a/b and random out_ready for 1000 beats. Required: an in-order scoreboard matches every output against a^b, a&b and popcount(a&b); outputs stay stable while stalled.
- Mid-stream reset: assert rst_n low with both buffers full. Required: out_valid drops immediately and in_ready = 1; after release, the next beat is the first one delivered.
